// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM transmit scheduler: state and sample-source
// encodings plus default frame geometry.
package ofdm_pkg;

  localparam int DEF_N_SHORT = 160;
  localparam int DEF_N_LONG  = 160;
  localparam int DEF_N_FFT   = 64;
  localparam int DEF_N_CP    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHORT,
    ST_LONG,
    ST_WAIT_SYM,
    ST_DATA
  } state_t;

  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_SHORT = 2'd1,
    SRC_LONG  = 2'd2,
    SRC_BANK  = 2'd3
  } src_t;

endpackage

// File: rtl/ofdm_tx_scheduler_if.sv
// Control/status bundle between the frame scheduler (master) and the
// preamble ROMs, symbol banks and output mux it steers (slave).
interface ofdm_tx_scheduler_if;

  logic       en;
  logic       start;
  logic [7:0] num_symbols;
  logic [1:0] bank_full;
  logic       busy;
  logic       done;
  logic       sample_valid;
  logic [1:0] src_sel;
  logic [7:0] pre_addr;
  logic [5:0] sym_addr;
  logic       rd_bank;
  logic       bank_release;
  logic       underrun;

  modport master (
    input  en, start, num_symbols, bank_full,
    output busy, done, sample_valid, src_sel, pre_addr, sym_addr,
           rd_bank, bank_release, underrun
  );

  modport slave (
    output en, start, num_symbols, bank_full,
    input  busy, done, sample_valid, src_sel, pre_addr, sym_addr,
           rd_bank, bank_release, underrun
  );

endinterface

// File: rtl/ofdm_tx_scheduler.sv
// Frame sequencer: short preamble, long preamble, then num_symbols CP+IFFT
// symbols read alternately from a ping-pong bank pair. All outputs registered.
module ofdm_tx_scheduler
  import ofdm_pkg::*;
#(
  parameter int N_SHORT = DEF_N_SHORT,
  parameter int N_LONG  = DEF_N_LONG,
  parameter int N_FFT   = DEF_N_FFT,
  parameter int N_CP    = DEF_N_CP
) (
  input  logic                clk,
  input  logic                reset,
  ofdm_tx_scheduler_if.master bus
);

  localparam int         N_SYM    = N_FFT + N_CP;
  localparam logic [5:0] CP_START = 6'(N_FFT - N_CP);

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic [7:0] remaining;
  logic       last;
  logic       step;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    case (state)
      ST_SHORT: last = (cnt == 8'(N_SHORT - 1));
      ST_LONG:  last = (cnt == 8'(N_LONG - 1));
      ST_DATA:  last = (cnt == 8'(N_SYM - 1));
      default:  last = 1'b0;
    endcase

    state_n = state;
    step    = 1'b0;
    case (state)
      ST_IDLE:     if (bus.start) state_n = ST_SHORT;
      ST_SHORT:    if (last) state_n = ST_LONG; else step = 1'b1;
      ST_LONG: begin
        if (!last)                            step    = 1'b1;
        else if (remaining == 8'd0)           state_n = ST_IDLE;
        else if (bus.bank_full[bus.rd_bank])  state_n = ST_DATA;
        else                                  state_n = ST_WAIT_SYM;
      end
      ST_DATA: begin
        // rd_bank toggles on this edge, so the next symbol comes from the other bank
        if (!last)                            step    = 1'b1;
        else if (remaining == 8'd1)           state_n = ST_IDLE;
        else if (bus.bank_full[~bus.rd_bank]) state_n = ST_DATA;
        else                                  state_n = ST_WAIT_SYM;
      end
      ST_WAIT_SYM: if (bus.bank_full[bus.rd_bank]) state_n = ST_DATA;
      default:     state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      remaining        <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.src_sel      <= SRC_ZERO;
      bus.pre_addr     <= '0;
      bus.sym_addr     <= '0;
      bus.rd_bank      <= 1'b0;
      bus.bank_release <= 1'b0;
      bus.underrun     <= 1'b0;
    end else if (!bus.en) begin
      bus.sample_valid <= 1'b0;
      bus.done         <= 1'b0;
      bus.bank_release <= 1'b0;
    end else begin
      state            <= state_n;
      bus.done         <= 1'b0;
      bus.bank_release <= 1'b0;
      if (step) begin
        cnt              <= cnt + 8'd1;
        bus.sample_valid <= 1'b1;
        if (state == ST_DATA) begin
          bus.sym_addr     <= (bus.sym_addr == 6'(N_FFT - 1)) ? 6'd0 : bus.sym_addr + 6'd1;
          bus.bank_release <= (cnt == 8'(N_SYM - 2));
        end else begin
          bus.pre_addr <= cnt + 8'd1;
        end
      end else begin
        cnt          <= '0;
        bus.pre_addr <= '0;
        bus.sym_addr <= '0;
        case (state_n)
          ST_SHORT: begin
            bus.src_sel      <= SRC_SHORT;
            bus.sample_valid <= 1'b1;
          end
          ST_LONG: begin
            bus.src_sel      <= SRC_LONG;
            bus.sample_valid <= 1'b1;
          end
          ST_DATA: begin
            bus.src_sel      <= SRC_BANK;
            bus.sample_valid <= 1'b1;
            bus.sym_addr     <= CP_START;
          end
          ST_WAIT_SYM: begin
            bus.src_sel      <= SRC_ZERO;
            bus.sample_valid <= 1'b0;
            bus.underrun     <= 1'b1;
          end
          default: begin
            bus.src_sel      <= SRC_ZERO;
            bus.sample_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= (state != ST_IDLE);
          end
        endcase
      end
      if (state == ST_IDLE && bus.start) begin
        remaining    <= bus.num_symbols;
        bus.underrun <= 1'b0;
        bus.busy     <= 1'b1;
      end
      if (state == ST_DATA && last) begin
        bus.rd_bank <= ~bus.rd_bank;
        remaining   <= remaining - 8'd1;
      end
    end
  end

endmodule

// File: doc/ofdm_tx_scheduler.md
OFDM_TX_SCHEDULER -- requirements
Module: ofdm_tx_scheduler

Interface
REQ-001 Parameter N_SHORT, 160, short-preamble length in samples.
REQ-002 Parameter N_LONG, 160, long-preamble length in samples (32 GI + 2x64).
REQ-003 Parameter N_FFT, 64, IFFT symbol length; power of two.
REQ-004 Parameter N_CP, 16, cyclic-prefix length; N_CP < N_FFT.
REQ-005 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 en  in  1  clock enable; when low, all state and counters hold.
REQ-009 start  in  1  frame request pulse, accepted only in IDLE.
REQ-010 num_symbols  in  8  data symbols in the frame, latched on start.
REQ-011 bank_full  in  2  per-bank flag: ping-pong symbol bank holds a complete IFFT symbol.
REQ-012 busy  out  1  high from start acceptance until done.
REQ-013 done  out  1  one-cycle pulse at frame end.
REQ-014 sample_valid  out  1  current-cycle sample is part of the frame.
REQ-015 src_sel  out  2  sample source: 0 zero, 1 short ROM, 2 long ROM, 3 symbol bank.
REQ-016 pre_addr  out  8  preamble ROM sample index.
REQ-017 sym_addr  out  6  read address inside the selected bank.
REQ-018 rd_bank  out  1  bank being read.
REQ-019 bank_release  out  1  one-cycle pulse: rd_bank fully read, producer may refill.
REQ-020 underrun  out  1  sticky: a symbol gap occurred in this frame.

Function
REQ-021 States SHALL be IDLE, SHORT, LONG, WAIT_SYM, DATA; all transitions occur only on edges with en=1.
REQ-022 IDLE: start=1 SHALL latch num_symbols, clear underrun, set busy, enter SHORT; start in any other state is ignored.
REQ-023 SHORT: pre_addr counts 0..N_SHORT-1, one per enabled cycle, src_sel=1; after index N_SHORT-1, enter LONG with pre_addr=0.
REQ-024 LONG: pre_addr counts 0..N_LONG-1, src_sel=2; after the last index, enter IDLE if latched count = 0, else DATA if bank_full[rd_bank], else WAIT_SYM.
REQ-025 DATA: sample counter c runs 0..N_FFT+N_CP-1; sym_addr = (c - N_CP) mod N_FFT (CP sent first: 48..63, then 0..63); src_sel=3.
REQ-026 On the last DATA sample, the block SHALL pulse bank_release for rd_bank, toggle rd_bank, and decrement the remaining count.
REQ-027 After the last DATA sample: remaining = 0 -> IDLE; else next bank full -> DATA, no gap cycle; else WAIT_SYM.
REQ-028 WAIT_SYM: sample_valid=0, src_sel=0, and underrun set on entry; enter DATA with c=0 when bank_full[rd_bank]=1.
REQ-029 sample_valid SHALL be 1 exactly in SHORT, LONG and DATA cycles with en=1.
REQ-030 done SHALL pulse in the cycle after the final sample, together with busy falling.
REQ-031 When en=0, outputs SHALL hold, except sample_valid=0 and no pulses (done, bank_release).
REQ-032 All outputs SHALL be registered; src_sel, pre_addr and sym_addr describe the same cycle as sample_valid.

Reset
REQ-033 reset SHALL force IDLE, counters 0, rd_bank 0, and busy, done, sample_valid, bank_release, underrun, src_sel, pre_addr, sym_addr all 0.
REQ-034 reset SHALL override start and en in the same cycle; reset mid-frame aborts without bank_release.

Structure
REQ-035 State encodings, src_sel codes and default lengths SHALL reside in shared package ofdm_pkg.
REQ-036 The block SHALL be a single FSM plus counters; it instantiates no sub-module and feeds the existing preamble ROMs, symbol memory and output mux.

Verification
REQ-037 Frame, num_symbols=2, both banks full, en=1: 160 src_sel=1, 160 src_sel=2, 160 src_sel=3 contiguous; 480 valid; done at cycle 481; 2 bank_release pulses.
REQ-038 Symbol addressing: first DATA symbol sym_addr sequence is 48..63, then 0..63; release on sample 79.
REQ-039 Gap: bank 1 empty at end of symbol 0 for 5 cycles -> 5 invalid WAIT_SYM cycles, underrun=1, resumes at sym_addr 48.
REQ-040 num_symbols=0 -> 320 valid samples, no bank_release, done pulse.
REQ-041 en toggled 1/0 every cycle -> identical sample sequence, frame takes 2x cycles.
REQ-042 reset at LONG index 50 -> all outputs 0 next cycle; start while busy ignored.
